// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - AD7888 channel scan scheduler with one-frame pipeline priming.
// Optional wait watchdog is compiled in with ADC_SEQ_TIMEOUT_EN.
module adc_scan_sequencer #(
  parameter int NUM_CH      = 8,
  parameter int GAP_W       = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              i_sclk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_continuous,
  input  logic [NUM_CH-1:0] i_ch_mask,
  input  logic [GAP_W-1:0]  i_gap,
  output logic              o_wr_en,
  input  logic              i_wr_done,
  output logic              o_rd_en,
  input  logic              i_rd_done,
  input  logic [15:0]       i_rd_data,
  output logic [2:0]        o_ch_sel,
  output logic              o_sample_valid,
  output logic [2:0]        o_sample_ch,
  output logic [11:0]       o_sample_data,
  output logic              o_busy,
  output logic              o_scan_done,
  output logic              o_timeout_err
);

  typedef enum logic [2:0] {IDLE, NEXT, WR, WAIT_WR, RD, WAIT_RD, EMIT, GAP} state_t;

  state_t             state, next_state;
  logic [NUM_CH-1:0]  mask_reg;
  logic [GAP_W-1:0]   gap_reg;
  logic [GAP_W-1:0]   gap_cnt;
  logic               cont_reg;
  logic               prime;
  logic               stop_pending;
  logic [2:0]         ptr;
  logic [2:0]         prev_ch;
  logic [2:0]         hi_ch;
  logic               end_pass;
  logic               take_sample;
  logic               tmo_hit;
  logic               tmo_fire;
  logic [3:0]         unused_rd;

  assign unused_rd = i_rd_data[15:12];

  function automatic logic [2:0] lowest_bit(input logic [NUM_CH-1:0] m);
    lowest_bit = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i]) lowest_bit = 3'(i);
  endfunction

  function automatic logic [2:0] highest_bit(input logic [NUM_CH-1:0] m);
    highest_bit = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (m[i]) highest_bit = 3'(i);
  endfunction

  // Lowest set bit strictly above p; falls back to the lowest set bit (wrap).
  function automatic logic [2:0] next_bit(input logic [NUM_CH-1:0] m, input logic [2:0] p);
    next_bit = lowest_bit(m);
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i] && (i > int'(p))) next_bit = 3'(i);
  endfunction

  assign hi_ch       = highest_bit(mask_reg);
  assign end_pass    = !prime && (prev_ch == hi_ch);
  assign take_sample = (state == WAIT_RD) && i_rd_done;

  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    tmo_fire   = 1'b0;
    case (state)
      IDLE:    if (i_start && (|i_ch_mask)) next_state = NEXT;
      NEXT:    next_state = WR;
      WR:      next_state = WAIT_WR;
      WAIT_WR: begin
        if (i_wr_done) next_state = RD;
        else if (tmo_hit) begin
          next_state = IDLE;
          tmo_fire   = 1'b1;
        end
      end
      RD:      next_state = WAIT_RD;
      WAIT_RD: begin
        if (i_rd_done) next_state = EMIT;
        else if (tmo_hit) begin
          next_state = IDLE;
          tmo_fire   = 1'b1;
        end
      end
      EMIT: begin
        if (stop_pending || i_stop || (end_pass && !cont_reg)) next_state = IDLE;
        else                                                    next_state = GAP;
      end
      GAP:     if (gap_cnt <= GAP_W'(1)) next_state = NEXT;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wr_en        <= 1'b0;
      o_rd_en        <= 1'b0;
      o_busy         <= 1'b0;
      o_sample_valid <= 1'b0;
      o_scan_done    <= 1'b0;
      o_sample_ch    <= '0;
      o_sample_data  <= '0;
      o_ch_sel       <= '0;
      mask_reg       <= '0;
      gap_reg        <= '0;
      gap_cnt        <= '0;
      cont_reg       <= 1'b0;
      prime          <= 1'b0;
      stop_pending   <= 1'b0;
      ptr            <= '0;
      prev_ch        <= '0;
    end else begin
      o_wr_en        <= (next_state == WR);
      o_rd_en        <= (next_state == RD);
      o_busy         <= (next_state != IDLE);
      o_sample_valid <= take_sample && !prime;
      o_scan_done    <= take_sample && end_pass;
      if (take_sample) begin
        o_sample_ch   <= prev_ch;
        o_sample_data <= i_rd_data[11:0];
      end
      case (state)
        IDLE: begin
          stop_pending <= 1'b0;
          if (i_start && (|i_ch_mask)) begin
            mask_reg <= i_ch_mask;
            gap_reg  <= i_gap;
            cont_reg <= i_continuous;
            prime    <= 1'b1;
            ptr      <= lowest_bit(i_ch_mask);
          end
        end
        NEXT: o_ch_sel <= ptr;
        EMIT: begin
          prev_ch <= ptr;
          prime   <= 1'b0;
          ptr     <= next_bit(mask_reg, ptr);
          gap_cnt <= gap_reg;
        end
        GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
        default: ;
      endcase
      if ((state != IDLE) && i_stop) stop_pending <= 1'b1;
    end
  end

`ifdef ADC_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_cnt       <= '0;
      o_timeout_err <= 1'b0;
    end else begin
      if (((state == WAIT_WR) || (state == WAIT_RD)) && (next_state == state))
        tmo_cnt <= tmo_cnt + TW'(1);
      else
        tmo_cnt <= '0;
      if ((state == IDLE) && i_start) o_timeout_err <= 1'b0;
      else if (tmo_fire)              o_timeout_err <= 1'b1;
    end
  end
`else
  localparam int unused_tmo_cyc = TIMEOUT_CYC;
  logic unused_tmo_fire;
  assign unused_tmo_fire = tmo_fire;
  assign tmo_hit       = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb/tb_adc_scan_sequencer.sv - directed bench with AD7888 driver model and sample scoreboard.
module tb_adc_scan_sequencer;
  localparam int WR_LAT = 17;
  localparam int FRAME  = 2 + WR_LAT + 1 + 2 + 1;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, cont = 1'b0;
  logic [7:0]  mask = '0;
  logic [15:0] gap = '0;
  logic        wr_done = 1'b0, rd_done = 1'b0;
  logic [15:0] rd_data = '0;
  logic        wr_en, rd_en, sample_valid, busy, scan_done, timeout_err;
  logic [2:0]  ch_sel, sample_ch;
  logic [11:0] sample_data;

  int tests = 0, fails = 0, cyc = 0;
  int wr_total = 0, rd_total = 0, done_total = 0, samp_total = 0;
  int wr_times[$];
  logic [14:0] exp_q[$];
  logic [2:0] sel_at_wr = '0;
  bit drv_hold = 1'b0;

  adc_scan_sequencer dut (
    .i_sclk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
    .i_continuous(cont), .i_ch_mask(mask), .i_gap(gap),
    .o_wr_en(wr_en), .i_wr_done(wr_done), .o_rd_en(rd_en), .i_rd_done(rd_done),
    .i_rd_data(rd_data), .o_ch_sel(ch_sel), .o_sample_valid(sample_valid),
    .o_sample_ch(sample_ch), .o_sample_data(sample_data), .o_busy(busy),
    .o_scan_done(scan_done), .o_timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [11:0] code(input int k);
    return 12'(32'h111 * (k + 1));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: one pass yields every enabled channel once, ascending, with its own code.
  task automatic push_pass(input logic [7:0] m);
    for (int k = 0; k < 8; k++)
      if (m[k]) exp_q.push_back({3'(k), code(k)});
  endtask

  // AD7888 + SPI driver: data returned in a frame belongs to the previous frame's channel.
  initial begin : driver
    int wr_cnt = 0;
    int rd_cnt = 0;
    logic [2:0] last_ch = '0;
    logic [2:0] cur_ch = '0;
    forever begin
      @(negedge clk);
      wr_done = 1'b0;
      rd_done = 1'b0;
      if (!rst_n) begin
        wr_cnt = 0;
        rd_cnt = 0;
      end else begin
        if (wr_cnt > 0) begin
          wr_cnt--;
          if (wr_cnt == 0) wr_done = 1'b1;
        end
        if (rd_cnt > 0) begin
          rd_cnt--;
          if (rd_cnt == 0) begin
            rd_done = 1'b1;
            rd_data = {4'hA, code(int'(last_ch))};
            last_ch = cur_ch;
          end
        end
        if (wr_en && !drv_hold) begin
          wr_cnt = WR_LAT;
          cur_ch = ch_sel;
        end
        if (rd_en) rd_cnt = 2;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [14:0] e;
    if (rst_n) begin
      if (wr_en || rd_en) check("wr_rd_exclusive", int'(wr_en & rd_en), 0);
      if (wr_en) begin
        wr_total++;
        wr_times.push_back(cyc);
        sel_at_wr = ch_sel;
      end
      if (rd_en) begin
        rd_total++;
        check("ch_sel_stable", int'(ch_sel), int'(sel_at_wr));
      end
      if (scan_done) done_total++;
      if (sample_valid) begin
        samp_total++;
        check("sample_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sample_ch", int'(sample_ch), int'(e[14:12]));
          check("sample_data", int'(sample_data), int'(e[11:0]));
        end
      end
    end
  end

  task automatic do_start(input logic [7:0] m, input logic [15:0] g, input logic c);
    @(negedge clk);
    mask = m; gap = g; cont = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int n = 0; n < budget && busy; n++) begin
      @(posedge clk); #1;
    end
    check({name, "_idle"}, int'(busy), 0);
  endtask

  task automatic wait_wr(input string name);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!wr_en && n < 200);
    check({name, "_wr_seen"}, int'(wr_en), 1);
  endtask

  task automatic check_spacing(input string name, input int first, input int exp);
    for (int i = first + 1; i < wr_times.size(); i++)
      check(name, wr_times[i] - wr_times[i-1], exp);
  endtask

  task automatic check_all_zero(input string p);
    check({p, "_busy"}, int'(busy), 0);
    check({p, "_wr_en"}, int'(wr_en), 0);
    check({p, "_rd_en"}, int'(rd_en), 0);
    check({p, "_ch_sel"}, int'(ch_sel), 0);
    check({p, "_valid"}, int'(sample_valid), 0);
    check({p, "_sample_ch"}, int'(sample_ch), 0);
    check({p, "_sample_data"}, int'(sample_data), 0);
    check({p, "_scan_done"}, int'(scan_done), 0);
    check({p, "_timeout"}, int'(timeout_err), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int bw, bd, bs, idx, n, rds;
    repeat (3) @(negedge clk);
    #1 check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Mask 0x05, gap 0, single pass: literal expectations.
    bw = wr_total; bd = done_total; idx = wr_times.size();
    exp_q.push_back({3'd0, 12'h111});
    exp_q.push_back({3'd2, 12'h333});
    do_start(8'h05, 16'd0, 1'b0);
    wait_idle("t1", 400);
    check("t1_frames", wr_total - bw, 3);
    check("t1_scan_done", done_total - bd, 1);
    check("t1_drained", exp_q.size(), 0);
    check_spacing("t1_spacing", idx, FRAME + 1);

    // Mask 0xA6, gap 3, single pass: model expectations.
    bw = wr_total; bd = done_total; idx = wr_times.size();
    push_pass(8'hA6);
    do_start(8'hA6, 16'd3, 1'b0);
    wait_idle("t2", 800);
    check("t2_frames", wr_total - bw, $countones(8'hA6) + 1);
    check("t2_scan_done", done_total - bd, 1);
    check("t2_drained", exp_q.size(), 0);
    check_spacing("t2_spacing", idx, FRAME + 3);

    // Mask 0x80, continuous, gap 10, then stop mid-frame.
    bw = wr_total; bd = done_total; bs = samp_total; idx = wr_times.size();
    for (int i = 0; i < 5; i++) exp_q.push_back({3'd7, 12'h888});
    do_start(8'h80, 16'd10, 1'b1);
    n = 0;
    while (samp_total - bs < 4 && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    check("t3_four_samples", samp_total - bs, 4);
    wait_wr("t3");
    repeat (5) @(posedge clk);
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!sample_valid && n < 100);
    check("t3_stop_sample", int'(sample_valid), 1);
    @(posedge clk); #1;
    check("t3_busy_after_emit", int'(busy), 0);
    repeat (60) @(posedge clk);
    #1;
    check("t3_frames", wr_total - bw, 6);
    check("t3_scan_done", done_total - bd, 5);
    check("t3_drained", exp_q.size(), 0);
    check_spacing("t3_spacing", idx, FRAME + 10);

    // Start with zero mask, then start while busy.
    bw = wr_total;
    do_start(8'h00, 16'd5, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("t4_zero_mask_busy", int'(busy), 0);
    check("t4_zero_mask_wr", wr_total - bw, 0);
    bd = done_total;
    exp_q.push_back({3'd0, 12'h111});
    do_start(8'h01, 16'd0, 1'b0);
    wait_wr("t4");
    repeat (3) @(posedge clk);
    do_start(8'hFF, 16'd0, 1'b1);
    wait_idle("t4", 400);
    check("t4_busy_start_frames", wr_total - bw, 2);
    check("t4_scan_done", done_total - bd, 1);
    check("t4_drained", exp_q.size(), 0);

    // Reset during WAIT_RD of the sample-bearing frame.
    bs = samp_total; rds = rd_total;
    do_start(8'h03, 16'd0, 1'b0);
    n = 0;
    while (rd_total - rds < 2 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check("t5_second_rd", rd_total - rds, 2);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 check_all_zero("t5_rst");
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    check("t5_no_sample", samp_total - bs, 0);
    exp_q.push_back({3'd0, 12'h111});
    do_start(8'h01, 16'd0, 1'b0);
    wait_idle("t5", 400);
    check("t5_restart_samples", samp_total - bs, 1);
    check("t5_drained", exp_q.size(), 0);

`ifdef ADC_SEQ_TIMEOUT_EN
    drv_hold = 1'b1;
    bs = samp_total;
    do_start(8'h01, 16'd0, 1'b0);
    wait_wr("t6");
    repeat (64) @(posedge clk);
    #1;
    check("t6_err_before", int'(timeout_err), 0);
    check("t6_busy_before", int'(busy), 1);
    @(posedge clk); #1;
    check("t6_err_set", int'(timeout_err), 1);
    check("t6_idle", int'(busy), 0);
    drv_hold = 1'b0;
    exp_q.push_back({3'd0, 12'h111});
    do_start(8'h01, 16'd0, 1'b0);
    check("t6_err_cleared", int'(timeout_err), 0);
    wait_idle("t6", 400);
    check("t6_samples", samp_total - bs, 1);
    check("t6_drained", exp_q.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/adc_scan_sequencer.md
# adc_scan_sequencer

Scheduler sitting directly above the AD7888 SPI driver: it walks an enabled-channel mask, issues one write/read transaction pair per frame, and tags each returned 12-bit result with the channel it belongs to. The AD7888 returns in frame n the conversion for the channel programmed in frame n-1, so this block primes the pipeline with one discarded frame per scan. It also paces frames with a programmable inter-frame gap. It is the only master of the driver's `i_wr_en`/`i_rd_en` handshake.

## Interface
- `NUM_CH`, 8: number of ADC channels; fixes the `i_ch_mask` width.
- `GAP_W`, 16: width of the inter-frame gap counter.
- `TIMEOUT_CYC`, 64: watchdog limit in cycles on each done wait; used only with `ADC_SEQ_TIMEOUT_EN`.

Ports:
- `i_sclk` in 1: the single clock, same 10 kHz ADC clock as the driver.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_start` in 1: one-cycle pulse that starts a scan; ignored while `o_busy`=1.
- `i_stop` in 1: one-cycle pulse that stops the scan at the next frame boundary.
- `i_continuous` in 1: 1 = restart the scan after the last channel; sampled at `i_start`.
- `i_ch_mask` in NUM_CH: enabled channels, bit k = channel k; sampled at `i_start`.
- `i_gap` in GAP_W: idle cycles between frames; sampled at `i_start`.
- `o_wr_en` out 1: write-enable pulse to the driver.
- `i_wr_done` in 1: write-done from the driver.
- `o_rd_en` out 1: read-enable pulse to the driver.
- `i_rd_done` in 1: read-done from the driver.
- `i_rd_data` in 16: readout word from the driver.
- `o_ch_sel` out 3: channel address for the driver's control word; held stable for the whole frame.
- `o_sample_valid` out 1: one-cycle strobe for a tagged result.
- `o_sample_ch` out 3: channel tag of the result.
- `o_sample_data` out 12: result, `i_rd_data[11:0]`.
- `o_busy` out 1: high whenever the state is not IDLE.
- `o_scan_done` out 1: one-cycle pulse after the last channel of a pass.
- `o_timeout_err` out 1: sticky watchdog flag; cleared by `i_start`.

## Operation
- All outputs reset to 0, and the state resets to IDLE.
- States are IDLE, NEXT, WR, WAIT_WR, RD, WAIT_RD, EMIT, GAP.
- **IDLE**
  - `i_start` with a nonzero mask latches mask, gap and continuous.
  - It sets `prime`=1 and the channel pointer to the lowest set bit, then goes to NEXT.
  - `i_start` with a zero mask is ignored and the block stays in IDLE.
- **NEXT**: drive `o_ch_sel` from the pointer, then go to WR.
- **WR**: `o_wr_en`=1 for exactly this cycle, then go to WAIT_WR.
- **WAIT_WR**: wait for `i_wr_done`=1, which is a single-cycle level in the driver. On it, go to RD.
- **RD**: `o_rd_en`=1 for exactly this cycle, then go to WAIT_RD.
- **WAIT_RD**: on `i_rd_done`, capture `i_rd_data[11:0]` and go to EMIT.
- **EMIT**
  - If `prime`=0: pulse `o_sample_valid` with `o_sample_ch` = the previous frame's channel (`prev_ch`).
  - Always:
    - `prev_ch` ← the current pointer.
    - `prime` ← 0.
    - The pointer advances to the next set mask bit above it, wrapping to the lowest set bit.
- **End of pass**: the pass ends on the EMIT of the frame whose `prev_ch` was the highest set bit.
  - `o_scan_done` pulses in that EMIT cycle.
  - If continuous and no stop is pending: go to GAP.
  - Otherwise: go to IDLE.
- **Frame count**: a pass is popcount(mask)+1 frames, because the extra frame flushes the last channel.
  - In continuous mode the pipeline stays primed, so later passes take popcount(mask) frames.
  - `prime` stays 0 in later passes.
- **GAP**
  - Counts `i_gap` cycles, then goes to NEXT.
  - With `i_gap`=0, GAP lasts 1 cycle.
  - The gap also follows every non-final EMIT.
- **Stop**: an `i_stop` pulse sets a pending flag.
  - The block finishes the current frame, emits its sample, then goes to IDLE.
  - A stop pulse in IDLE is ignored.
- **Reset mid-frame**: the state machine returns to IDLE asynchronously, and no sample is emitted.
- **Arithmetic**:
  - The pointer is 3 bits.
  - The next-bit search is combinational over NUM_CH.
  - The gap counter saturates at 0.

## Timing
- `o_wr_en` and `o_rd_en` are registered single-cycle pulses, and they are never high together.
- The WR → `i_wr_done` wait is about 17 cycles with the current driver.
- `i_rd_done` arrives 2 cycles after `o_rd_en`, and data is valid on that same cycle.
- `o_sample_valid` comes 1 cycle after `i_rd_done`.
- A `i_wr_done` or `i_rd_done` pulse arriving in any state other than its wait state is ignored.

## Configuration
- **`ADC_SEQ_TIMEOUT_EN` defined**
  - Each WAIT_* state counts cycles.
  - After TIMEOUT_CYC cycles the block sets `o_timeout_err`, drops the frame without emitting a sample, and goes to IDLE.
- **Undefined**
  - The waits are unbounded, `o_timeout_err` is tied to 0, and there is no counter logic.

## Test plan
- Mask 0x05, gap 0, single pass, with a model that returns the prior channel's code: 3 frames run, samples are (ch0, 0x111) then (ch2, 0x333), `o_scan_done` pulses once, then IDLE.
- Mask 0x80, continuous, gap 10: after the first pass each frame emits ch7, and frame starts are spaced by the frame length + 10 cycles.
- `i_stop` mid-frame in continuous mode: the current sample is emitted, there is no further `o_wr_en`, and `o_busy`=0 by the end of that EMIT's cycle.
- `i_start` with mask 0x00, and `i_start` while busy: no `o_wr_en`, and the state is unchanged.
- `i_rst_n` low during WAIT_RD: all outputs are 0 at once and no `o_sample_valid`; after release, a fresh start with mask 0x01 works.
- With `ADC_SEQ_TIMEOUT_EN` and the driver holding `i_wr_done`=0: `o_timeout_err`=1 after 64 cycles, then IDLE, and the flag clears on the next `i_start`.
